// File: rtl/fwnoc_router_egress_arb.sv
// Round-robin egress arbiter for a NoC router: one ingress port owns the egress
// link for a whole packet, whose length comes from the header flit size code.
module fwnoc_router_egress_arb #(
  parameter int N_PORTS = 4,
  parameter int DAT_W   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         i_valid,
  output logic [N_PORTS-1:0]         i_ready,
  input  logic [N_PORTS*DAT_W-1:0]   i_dat,
  output logic                       e_valid,
  input  logic                       e_ready,
  output logic [DAT_W-1:0]           e_dat,
  output logic [N_PORTS-1:0]         gnt,
  output logic                       pkt_done,
  output logic                       err_size,
  output logic                       dbg_state_o
);

  localparam int OWN_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {ST_IDLE, ST_XFER} state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_q, last_d;
  logic [4:0]         rem_q, rem_d;
  logic               err_q, err_d;
  logic [OWN_W-1:0]   winner;
  logic               found;
  logic [3:0]         win_code;
  logic               hs;

  // Flits in a packet, header included; illegal codes degrade to header-only.
  function automatic logic [4:0] flits_for(input logic [3:0] code);
    case (code)
      4'd0:    flits_for = 5'd1;
      4'd1:    flits_for = 5'd2;
      4'd2:    flits_for = 5'd3;
      4'd3:    flits_for = 5'd5;
      4'd4:    flits_for = 5'd9;
      4'd5:    flits_for = 5'd17;
      default: flits_for = 5'd1;
    endcase
  endfunction

  // Search starts one past the last owner so it loses ties to everyone else.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int off = 1; off <= N_PORTS; off++) begin
      if (!found && i_valid[(int'(last_q) + off) % N_PORTS]) begin
        found  = 1'b1;
        winner = OWN_W'((int'(last_q) + off) % N_PORTS);
      end
    end
  end

  assign win_code = i_dat[int'(winner)*DAT_W +: 4];

  // Egress handshake: a flit moves when e_valid && e_ready in the same cycle;
  // e_valid never depends on e_ready, and i_ready of the owner is e_ready.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rem_d    = rem_q;
    err_d    = 1'b0;
    i_ready  = '0;
    e_valid  = 1'b0;
    e_dat    = '0;
    gnt      = '0;
    pkt_done = 1'b0;
    hs       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_XFER;
          owner_d = winner;
          last_d  = winner;
          rem_d   = flits_for(win_code);
          err_d   = (win_code > 4'd5);
        end
      end
      ST_XFER: begin
        gnt[owner_q]     = 1'b1;
        e_valid          = i_valid[owner_q];
        e_dat            = i_dat[int'(owner_q)*DAT_W +: DAT_W];
        i_ready[owner_q] = e_ready;
        hs               = e_valid & e_ready;
        if (hs) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d  = ST_IDLE;
            pkt_done = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OWN_W'(N_PORTS - 1);
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign err_size    = err_q;
  assign dbg_state_o = (state_q == ST_XFER);

endmodule

// File: tb/tb_fwnoc_router_egress_arb.sv
// Directed bench for fwnoc_router_egress_arb: egress flits are checked against a
// scoreboard queue, grants/handshake timing with immediate assertions.
module tb_fwnoc_router_egress_arb;
  localparam int NP = 4;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NP-1:0]      i_valid = '0;
  logic [NP-1:0]      i_ready;
  logic [NP*DW-1:0]   i_dat = '0;
  logic               e_valid;
  logic               e_ready = 1'b0;
  logic [DW-1:0]      e_dat;
  logic [NP-1:0]      gnt;
  logic               pkt_done;
  logic               err_size;
  logic               dbg_state;

  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int exp_done = 0;

  fwnoc_router_egress_arb #(.N_PORTS(NP), .DAT_W(DW)) dut (
    .clock      (clk),
    .reset      (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_dat      (i_dat),
    .e_valid    (e_valid),
    .e_ready    (e_ready),
    .e_dat      (e_dat),
    .gnt        (gnt),
    .pkt_done   (pkt_done),
    .err_size   (err_size),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_payload(input logic [3:0] c);
    case (c)
      4'd0: return 0;
      4'd1: return 1;
      4'd2: return 2;
      4'd3: return 4;
      4'd4: return 8;
      4'd5: return 16;
      default: return 0;
    endcase
  endfunction

  // scoreboard: every accepted egress flit must be the oldest expected one
  always @(negedge clk) begin
    if (!rst && e_valid === 1'b1 && e_ready === 1'b1) begin
      if (exp_q.size() == 0) check("egress_unexpected", 32'(exp_q.size()), 32'd1);
      else check("egress_flit", e_dat, exp_q.pop_front());
    end
    if (!rst && pkt_done === 1'b1) n_done++;
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [DW-1:0] d);
    i_valid[p]       = v;
    i_dat[p*DW +: DW] = d;
  endtask

  // Called in an IDLE cycle; offers a packet on port p and follows it to the end.
  task automatic xfer_pkt(input int p, input logic [3:0] code, input int rmode,
                          input int stall_at, input int stall_len, input bit keep,
                          output int cycles);
    logic [DW-1:0] fl [17];
    logic [31:0]   r;
    logic [NP-1:0] onehot;
    int nf, k, cyc, sl;
    logic v, rd;
    nf = exp_payload(code) + 1;
    r = $urandom();
    fl[0] = {r[31:4], code};
    for (int i = 1; i < nf; i++) fl[i] = $urandom();
    for (int i = 0; i < nf; i++) exp_q.push_back(fl[i]);
    onehot = '0;
    onehot[p] = 1'b1;
    set_port(p, 1'b1, fl[0]);
    e_ready = 1'b1;
    @(negedge clk);
    check("arb_gnt", 32'(gnt), 32'd0);
    check("arb_evalid", 32'(e_valid), 32'd0);
    check("arb_iready", 32'(i_ready), 32'd0);
    check("arb_done", 32'(pkt_done), 32'd0);
    check("arb_err", 32'(err_size), 32'd0);
    check("arb_state", 32'(dbg_state), 32'd0);
    tick;
    k = 0; cyc = 0; sl = stall_len;
    while (k < nf && cyc < 64) begin
      v = !(k == stall_at && sl > 0);
      if (!v) sl--;
      rd = (rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
      set_port(p, v, fl[k]);
      e_ready = rd;
      @(negedge clk);
      check("x_gnt", 32'(gnt), 32'(onehot));
      check("x_state", 32'(dbg_state), 32'd1);
      check("x_evalid", 32'(e_valid), 32'(v));
      check("x_iready", 32'(i_ready), 32'(rd ? onehot : {NP{1'b0}}));
      check("x_done", 32'(pkt_done), 32'(v && rd && (k == nf - 1)));
      check("x_err", 32'(err_size), 32'((cyc == 0) && (code > 4'd5)));
      if (v && rd) k++;
      tick;
      cyc++;
    end
    check("x_complete", 32'(k), 32'(nf));
    if (k == nf) exp_done++;
    if (!keep) i_valid[p] = 1'b0;
    cycles = cyc;
  endtask

  initial begin
    int cyc;
    logic [31:0] r;
    logic [DW-1:0] h, p1;

    // reset state
    tick; tick;
    rst = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_evalid", 32'(e_valid), 32'd0);
    check("rst_iready", 32'(i_ready), 32'd0);
    check("rst_edat", e_dat, 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_err", 32'(err_size), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick;

    // port 2, code 3: five flits back to back, then idle
    xfer_pkt(2, 4'd3, 0, -1, 0, 1'b0, cyc);
    check("p2_cycles", 32'(cyc), 32'd5);
    @(negedge clk);
    check("p2_after_gnt", 32'(gnt), 32'd0);
    check("p2_after_evalid", 32'(e_valid), 32'd0);
    tick;

    // all ports requesting code 0 after reset: grant order 0,1,2,3,0
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      r = $urandom();
      set_port(p, 1'b1, {r[31:4], 4'd0});
    end
    xfer_pkt(0, 4'd0, 0, -1, 0, 1'b1, cyc);
    check("rr0_cycles", 32'(cyc), 32'd1);
    xfer_pkt(1, 4'd0, 0, -1, 0, 1'b1, cyc);
    xfer_pkt(2, 4'd0, 0, -1, 0, 1'b1, cyc);
    xfer_pkt(3, 4'd0, 0, -1, 0, 1'b1, cyc);
    xfer_pkt(0, 4'd0, 0, -1, 0, 1'b0, cyc);
    i_valid = '0;
    tick;

    // port 1, code 2 with e_ready toggling 1,0,1,0,1
    xfer_pkt(1, 4'd2, 1, -1, 0, 1'b0, cyc);
    check("p1_toggle_cycles", 32'(cyc), 32'd5);
    tick;

    // port 0, illegal code 9: header-only with err_size
    xfer_pkt(0, 4'd9, 0, -1, 0, 1'b0, cyc);
    check("p0_err_cycles", 32'(cyc), 32'd1);
    @(negedge clk);
    check("p0_err_clear", 32'(err_size), 32'd0);
    tick;

    // reset after 2 of 9 flits on port 3, then port 0 wins over port 3
    r = $urandom();
    h = {r[31:4], 4'd4};
    p1 = $urandom();
    exp_q.push_back(h);
    exp_q.push_back(p1);
    set_port(3, 1'b1, h);
    e_ready = 1'b1;
    @(negedge clk);
    check("abort_arb_gnt", 32'(gnt), 32'd0);
    tick;
    @(negedge clk);
    check("abort_gnt0", 32'(gnt), 32'h8);
    tick;
    set_port(3, 1'b1, p1);
    @(negedge clk);
    check("abort_gnt1", 32'(gnt), 32'h8);
    check("abort_done1", 32'(pkt_done), 32'd0);
    tick;
    r = $urandom();
    set_port(3, 1'b1, r);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    r = $urandom();
    set_port(3, 1'b1, {r[31:4], 4'd1});
    xfer_pkt(0, 4'd0, 0, -1, 0, 1'b0, cyc);
    i_valid = '0;
    check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
    tick;

    // port 1 stalls 3 cycles mid-packet while port 2 waits
    r = $urandom();
    set_port(2, 1'b1, {r[31:4], 4'd0});
    xfer_pkt(1, 4'd3, 0, 2, 3, 1'b0, cyc);
    check("stall_cycles", 32'(cyc), 32'd8);
    xfer_pkt(2, 4'd0, 0, -1, 0, 1'b0, cyc);
    tick;

    // a few single-requester packets with random port/code/ready pattern
    for (int n = 0; n < 4; n++) begin
      xfer_pkt($urandom_range(0, NP - 1), 4'($urandom_range(0, 15)),
               $urandom_range(0, 1), -1, 0, 1'b0, cyc);
      tick;
    end

    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_pkt_done_count", 32'(n_done), 32'(exp_done));
    check("final_idle_gnt", 32'(gnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fwnoc_router_egress_arb.md
FWNOC_ROUTER_EGRESS_ARB -- requirements
Module: fwnoc_router_egress_arb

Interface
REQ-001 Parameter N_PORTS, default 4, number of ingress ports (legal 2..16).
REQ-002 Parameter DAT_W, default 32, flit width in bits (legal 8..128).
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port i_valid  input  N_PORTS  per-ingress flit valid; bit k = port k.
REQ-006 Port i_ready  output  N_PORTS  per-ingress flit accept; bit k = port k.
REQ-007 Port i_dat  input  N_PORTS*DAT_W  flattened ingress flits; port k at bits [k*DAT_W +: DAT_W].
REQ-008 Port e_valid  output  1  egress flit valid.
REQ-009 Port e_ready  input  1  egress flit accept.
REQ-010 Port e_dat  output  DAT_W  egress flit.
REQ-011 Port gnt  output  N_PORTS  one-hot current owner; zero when idle.
REQ-012 Port pkt_done  output  1  one-cycle pulse on final flit handshake of a packet.
REQ-013 Port err_size  output  1  one-cycle pulse when an illegal size code is latched.

Function
REQ-014 Packet = 1 header flit + P payload flits; size code = header dat[3:0]; codes 0,1,2,3,4,5 -> P = 0,1,2,4,8,16.
REQ-015 Codes 6..15 -> P = 0 (header-only packet) and err_size pulses in the cycle after the latch.
REQ-016 States: IDLE, XFER; reset state IDLE.
REQ-017 IDLE: all i_ready = 0, e_valid = 0, gnt = 0, e_dat = 0.
REQ-018 IDLE with any i_valid set: winner = first requesting index strictly above last_owner, wrapping modulo N_PORTS; next cycle state = XFER, gnt = winner, remaining = P+1 decoded from winner's i_dat.
REQ-019 last_owner resets to N_PORTS-1, so port 0 has first priority after reset.
REQ-020 last_owner updates to the winner when XFER is entered.
REQ-021 A port that was the last owner is granted again only if no other port requests (round-robin fairness).
REQ-022 XFER: e_valid = i_valid[g], e_dat = i_dat slice g, i_ready[g] = e_ready, i_ready of all other ports = 0.
REQ-023 XFER: each cycle with e_valid & e_ready decrements remaining by 1; the decrement to 0 returns state to IDLE and pulses pkt_done in that same cycle.
REQ-024 Owner held for the whole packet; other ports' i_valid ignored in XFER, including when the owner deasserts i_valid mid-packet (stall, no abort).
REQ-025 Minimum gap between packets: one IDLE cycle (arbitration cycle) after each pkt_done.
REQ-026 remaining width 5 bits; max value 17; no wrap possible.
REQ-027 e_valid combinational from i_valid[g]; e_dat and i_ready are combinational; no flit buffering inside the block.
REQ-028 No combinational path from e_ready to e_valid.

Reset
REQ-029 reset asserted in any state: next edge state = IDLE, remaining = 0, last_owner = N_PORTS-1, gnt = 0, pkt_done = 0, err_size = 0.
REQ-030 Reset mid-packet discards the packet; no pkt_done for it; ingress ports see i_ready = 0 from the cycle after reset is sampled.
REQ-031 Outputs within the reset cycle are don't-care; from the first cycle after reset, outputs match IDLE values.

Verification
REQ-032 N_PORTS=4: port 2 sends header code 3 with e_ready=1 constant -> gnt=4'b0100 one cycle later, 5 flits transferred in 5 consecutive cycles, pkt_done on the 5th, then gnt=0.
REQ-033 All 4 ports hold valid header code 0 continuously after reset -> grant order 0,1,2,3,0 with one IDLE cycle between each pkt_done and the next gnt.
REQ-034 Port 1 sending code 2, e_ready toggled 1,0,1,0,1 -> exactly 3 handshakes, i_ready[1] mirrors e_ready, pkt_done on the 3rd handshake only.
REQ-035 Port 0 header code 9 -> err_size pulses once, single-flit transfer, pkt_done on that flit.
REQ-036 Reset asserted after 2 of 9 flits of a code-4 packet on port 3 -> next cycle IDLE, gnt=0, no pkt_done; a following request from port 0 is granted first.
REQ-037 Owner port 1 drops i_valid for 3 cycles mid-packet while port 2 requests -> e_valid=0 during the gap, gnt stays 4'b0010, packet completes on port 1 before port 2 is granted.
